// File: rtl/ram_dual_clr.sv
// Dual-port synchronous RAM: port A read/write, port B read-only, with a built-in
// clear engine that sweeps the array to CLR_VAL after reset or on request.
module ram_dual_clr #(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DEPTH    = 65026,
    parameter int unsigned       RDW_MODE = 0,
    parameter int unsigned       OUT_REG  = 0,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    output logic [DATA_W-1:0] a_dout,
    output logic              a_valid,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_dout,
    output logic              b_valid,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    localparam int unsigned       IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_DONE  = 2'd1,
        S_IDLE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                busy_q, busy_d;
    logic                clr_done_q, clr_done_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                a_acc_c, b_acc_c;
    logic                a_in_rng_c, b_in_rng_c;
    logic                mem_we_c;
    logic [IDX_W-1:0]    mem_widx_c;
    logic [DATA_W-1:0]   mem_wdata_c;
    logic [DATA_W-1:0]   a_rd_c, b_rd_c;

    logic [DATA_W-1:0]   a_s1_data_q, a_s1_data_d;
    logic [DATA_W-1:0]   b_s1_data_q, b_s1_data_d;
    logic                a_s1_valid_q, a_s1_valid_d;
    logic                b_s1_valid_q, b_s1_valid_d;

    // Clear-engine FSM: next state, pointer and registered status flags
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_CLEAR: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = S_DONE;
                    ptr_d   = '0;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                ptr_d   = '0;
            end
        endcase
        busy_d     = (state_d == S_CLEAR);
        clr_done_d = (state_d == S_DONE);
    end

    // Access qualification and the single array write port (clear has priority)
    always_comb begin
        a_acc_c     = a_en && (state_q != S_CLEAR);
        b_acc_c     = b_en && (state_q != S_CLEAR);
        a_in_rng_c  = {1'b0, a_addr} < DEPTH_X;
        b_in_rng_c  = {1'b0, b_addr} < DEPTH_X;
        mem_we_c    = 1'b0;
        mem_widx_c  = '0;
        mem_wdata_c = '0;
        if (state_q == S_CLEAR) begin
            mem_we_c    = 1'b1;
            mem_widx_c  = IDX_W'(ptr_q);
            mem_wdata_c = CLR_VAL;
        end else if (a_acc_c && a_we && a_in_rng_c) begin
            mem_we_c    = 1'b1;
            mem_widx_c  = IDX_W'(a_addr);
            mem_wdata_c = a_din;
        end
    end

    // Read data: array contents sampled before this edge's write, so port B always sees old data
    always_comb begin
        a_rd_c = '0;
        b_rd_c = '0;
        if (a_in_rng_c) begin
            if (a_we && (RDW_MODE == 0)) begin
                a_rd_c = a_din;
            end else begin
                a_rd_c = mem[IDX_W'(a_addr)];
            end
        end
        if (b_in_rng_c) begin
            b_rd_c = mem[IDX_W'(b_addr)];
        end
        a_s1_valid_d = a_acc_c;
        b_s1_valid_d = b_acc_c;
        a_s1_data_d  = a_acc_c ? a_rd_c : a_s1_data_q;
        b_s1_data_d  = b_acc_c ? b_rd_c : b_s1_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CLEAR;
            ptr_q        <= '0;
            busy_q       <= 1'b1;
            clr_done_q   <= 1'b0;
            a_s1_data_q  <= '0;
            b_s1_data_q  <= '0;
            a_s1_valid_q <= 1'b0;
            b_s1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            busy_q       <= busy_d;
            clr_done_q   <= clr_done_d;
            a_s1_data_q  <= a_s1_data_d;
            b_s1_data_q  <= b_s1_data_d;
            a_s1_valid_q <= a_s1_valid_d;
            b_s1_valid_q <= b_s1_valid_d;
        end
    end

    // Array storage is deliberately not reset; the clear engine initialises it
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_widx_c] <= mem_wdata_c;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] a_s2_data_q, a_s2_data_d;
        logic [DATA_W-1:0] b_s2_data_q, b_s2_data_d;
        logic              a_s2_valid_q, a_s2_valid_d;
        logic              b_s2_valid_q, b_s2_valid_d;

        // Second stage only reloads on a valid beat so dout holds between reads
        always_comb begin
            a_s2_valid_d = a_s1_valid_q;
            b_s2_valid_d = b_s1_valid_q;
            a_s2_data_d  = a_s1_valid_q ? a_s1_data_q : a_s2_data_q;
            b_s2_data_d  = b_s1_valid_q ? b_s1_data_q : b_s2_data_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                a_s2_data_q  <= '0;
                b_s2_data_q  <= '0;
                a_s2_valid_q <= 1'b0;
                b_s2_valid_q <= 1'b0;
            end else begin
                a_s2_data_q  <= a_s2_data_d;
                b_s2_data_q  <= b_s2_data_d;
                a_s2_valid_q <= a_s2_valid_d;
                b_s2_valid_q <= b_s2_valid_d;
            end
        end

        assign a_dout  = a_s2_data_q;
        assign b_dout  = b_s2_data_q;
        assign a_valid = a_s2_valid_q;
        assign b_valid = b_s2_valid_q;
    end else begin : g_no_out_reg
        assign a_dout  = a_s1_data_q;
        assign b_dout  = b_s1_data_q;
        assign a_valid = a_s1_valid_q;
        assign b_valid = b_s1_valid_q;
    end

    assign busy     = busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_ram_dual_clr.sv
// Testbench for ram_dual_clr: two instances (write-first/no out reg/clear 0x00 and
// read-first/out reg/clear 0x3C) share stimulus; a queue scoreboard checks both read ports.
module tb_ram_dual_clr;

    localparam int unsigned DW  = 8;
    localparam int unsigned AW  = 5;
    localparam int unsigned DEP = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, clr_req = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_din = '0;

    logic [1:0][DW-1:0] a_dout, b_dout;
    logic [1:0]         a_valid, b_valid, busy, clr_done;

    ram_dual_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RDW_MODE(0), .OUT_REG(0),
                   .CLR_VAL(8'h00)) u_dut0 (
        .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout[0]), .a_valid(a_valid[0]), .b_en(b_en), .b_addr(b_addr),
        .b_dout(b_dout[0]), .b_valid(b_valid[0]), .clr_req(clr_req), .busy(busy[0]),
        .clr_done(clr_done[0]));

    ram_dual_clr #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RDW_MODE(1), .OUT_REG(1),
                   .CLR_VAL(8'h3C)) u_dut1 (
        .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
        .a_dout(a_dout[1]), .a_valid(a_valid[1]), .b_en(b_en), .b_addr(b_addr),
        .b_dout(b_dout[1]), .b_valid(b_valid[1]), .clr_req(clr_req), .busy(busy[1]),
        .clr_done(clr_done[1]));

    typedef struct {
        int            due;
        int            ch;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          sbq[$];
    logic [DW-1:0] mdl [2][DEP];
    logic [DW-1:0] last [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;
    bit            mon_on = 1'b0;

    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] clr_val(input int k);
        return (k == 0) ? 8'h00 : 8'h3C;
    endfunction

    // Scoreboard: channel = 2*dut + port (0 = A, 1 = B); no entry due means valid=0 and dout held
    logic          mv;
    bit            mf;
    logic [DW-1:0] md, me;
    logic [1:0]    mch;
    logic          mk;
    always @(negedge clk) begin
        if (mon_on) begin
            for (int c = 0; c < 4; c++) begin
                mch = 2'(c);
                mk  = mch[1];
                if (mch[0] == 1'b0) begin
                    mv = a_valid[mk];
                    md = a_dout[mk];
                end else begin
                    mv = b_valid[mk];
                    md = b_dout[mk];
                end
                mf = 1'b0;
                me = last[mch];
                for (int i = 0; i < sbq.size(); i++) begin
                    if (sbq[i].due == cyc && sbq[i].ch == c) begin
                        me = sbq[i].d;
                        mf = 1'b1;
                        sbq.delete(i);
                        break;
                    end
                end
                n_checks++;
                if (mv !== mf || md !== me)
                    $display("FAIL out dut%0d port%s cyc%0d: valid=%0b data=%02h, required valid=%0b data=%02h",
                             mk, mch[0] ? "B" : "A", cyc, mv, md, mf, me);
                else
                    n_pass++;
                last[mch] = me;
            end
        end
    end

    // One cycle of stimulus for an idle DUT; expectations pushed from the model
    task automatic step(input logic ae, input logic we, input logic [AW-1:0] aa,
                        input logic [DW-1:0] ad, input logic be, input logic [AW-1:0] ba,
                        input logic cr);
        exp_t e;
        @(posedge clk);
        #1;
        a_en = ae; a_we = we; a_addr = aa; a_din = ad;
        b_en = be; b_addr = ba; clr_req = cr;
        for (int k = 0; k < 2; k++) begin
            if (ae) begin
                e.due = cyc + 1 + k;
                e.ch  = 2 * k;
                if (aa >= 5'(DEP))        e.d = 8'h00;
                else if (we && k == 0)    e.d = ad;
                else                      e.d = mdl[k][aa[3:0]];
                sbq.push_back(e);
            end
            if (be) begin
                e.due = cyc + 1 + k;
                e.ch  = 2 * k + 1;
                e.d   = (ba >= 5'(DEP)) ? 8'h00 : mdl[k][ba[3:0]];
                sbq.push_back(e);
            end
            if (ae && we && aa < 5'(DEP)) mdl[k][aa[3:0]] = ad;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic model_cleared();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEP; i++) mdl[k][i] = clr_val(k);
    endtask

    // Busy/clr_done profile from sampling point j=0; optional junk accesses while clearing
    task automatic check_sweep(input int start, input bit junk);
        logic exp_b, exp_d;
        for (int j = 0; j <= start + 17; j++) begin
            @(negedge clk);
            exp_b = (j >= start) && (j < start + 16);
            exp_d = (j == start + 16);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (busy[k] !== exp_b || clr_done[k] !== exp_d)
                    $display("FAIL sweep dut%0d j=%0d: busy=%0b clr_done=%0b, required busy=%0b clr_done=%0b",
                             k, j, busy[k], clr_done[k], exp_b, exp_d);
                else
                    n_pass++;
            end
            if (junk && j >= start && j < start + 15) begin
                a_en = 1'b1; a_we = 1'b1; a_addr = 5'(j); a_din = 8'hEE;
                b_en = 1'b1; b_addr = 5'(j); clr_req = 1'b1;
            end else if (j >= start) begin
                a_en = 1'b0; a_we = 1'b0; b_en = 1'b0; clr_req = 1'b0;
            end
        end
        model_cleared();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (busy[k] !== 1'b1 || clr_done[k] !== 1'b0 || a_valid[k] !== 1'b0 ||
                b_valid[k] !== 1'b0 || a_dout[k] !== 8'h00 || b_dout[k] !== 8'h00)
                $display("FAIL reset dut%0d: busy=%0b done=%0b av=%0b bv=%0b ad=%02h bd=%02h, required 1 0 0 0 00 00",
                         k, busy[k], clr_done[k], a_valid[k], b_valid[k], a_dout[k], b_dout[k]);
            else
                n_pass++;
        end
        mon_on = 1'b1;
        rst = 1'b0;
        check_sweep(0, 1'b1);
    endtask

    task automatic test_readback();
        for (int i = 0; i < DEP; i++)
            step(1'b1, 1'b0, 5'(i), '0, 1'b1, 5'(DEP - 1 - i), 1'b0);
        idle(3);
    endtask

    task automatic test_write_read();
        step(1'b1, 1'b1, 5'd3, 8'hA5, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 1'b0);
        idle(3);
    endtask

    task automatic test_collision();
        step(1'b1, 1'b1, 5'd7, 8'h11, 1'b0, '0, 1'b0);
        idle(1);
        step(1'b1, 1'b1, 5'd7, 8'h22, 1'b1, 5'd7, 1'b0);
        step(1'b1, 1'b0, 5'd7, '0, 1'b1, 5'd7, 1'b0);
        idle(3);
    endtask

    task automatic test_out_of_range();
        step(1'b1, 1'b1, 5'd4, 8'h44, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 5'd20, 8'h5A, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 5'd20, '0, 1'b1, 5'd4, 1'b0);
        step(1'b1, 1'b1, 5'd16, 8'h66, 1'b1, 5'd31, 1'b0);
        step(1'b1, 1'b0, 5'd4, '0, 1'b1, 5'd20, 1'b0);
        step(1'b1, 1'b0, 5'd0, '0, 1'b1, 5'd16, 1'b0);
        idle(3);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b0);
        idle(3);
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int i = 0; i < DEP; i++) step(1'b1, 1'b1, 5'(i), v, 1'b0, '0, 1'b0);
        idle(3);
    endtask

    task automatic test_clr_req();
        fill(8'hFF);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        check_sweep(1, 1'b1);
        test_readback();
    endtask

    task automatic test_rst_mid_sweep();
        fill(8'h77);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        @(posedge clk);
        #1;
        clr_req = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (busy[k] !== 1'b1 || clr_done[k] !== 1'b0)
                $display("FAIL midsweep dut%0d: busy=%0b done=%0b, required 1 0", k, busy[k], clr_done[k]);
            else
                n_pass++;
        end
        rst = 1'b1;
        for (int c = 0; c < 4; c++) last[c] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_sweep(0, 1'b0);
        test_readback();
    endtask

    initial begin
        test_reset();
        test_readback();
        test_write_read();
        test_collision();
        test_out_of_range();
        test_back_to_back();
        test_clr_req();
        test_rst_mid_sweep();
        @(negedge clk);
        n_checks++;
        if (sbq.size() != 0)
            $display("FAIL drain: %0d expected reads never returned, required 0", sbq.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required finish before 500000");
        $fatal(1);
    end

endmodule
